// File: rtl/jtmikie_sndlatch.sv
// Main-to-sound command latch for the Mikie sound board: captures command bytes,
// drives the sound CPU IRQ, provides the polled sound timer and lost-command counters.
module jtmikie_sndlatch #(
  parameter int TIM_W = 10,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       main_latch,
  input  logic             m2s_on,
  input  logic             snd_rd,
  input  logic             snd_ack,
  input  logic             irq_en,
  input  logic             tim_cen,
  output logic [7:0]       latch_dout,
  output logic [3:0]       timer_dout,
  output logic             irqn,
  output logic             pending,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_cnt
);

  logic [7:0]       latch;
  logic             m2s_on_l;
  logic             armed;
  logic             wr;
  logic             pending_next;
  logic             ovr_hit;
  logic [TIM_W-1:0] timer;

  // armed only sets once m2s_on has been seen low, so a strobe already high
  // when reset releases is never mistaken for a rising edge.
  always_comb begin
    wr           = m2s_on & ~m2s_on_l & armed;
    pending_next = wr | (pending & ~snd_ack);
    ovr_hit      = wr & pending & ~snd_ack;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m2s_on_l <= 1'b0;
      armed    <= 1'b0;
    end else begin
      m2s_on_l <= m2s_on;
      if (!m2s_on) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latch      <= '0;
      latch_dout <= '0;
    end else begin
      // latch_dout samples the pre-write latch value when read and write coincide
      if (snd_rd) latch_dout <= latch;
      if (wr)     latch      <= main_latch;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
      irqn    <= 1'b1;
    end else begin
      pending <= pending_next;
      irqn    <= ~(pending_next & irq_en);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end else if (ovr_hit) begin
      overrun <= 1'b1;
      if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer      <= '0;
      timer_dout <= '0;
    end else begin
      if (tim_cen) timer <= timer + TIM_W'(1);
      timer_dout <= timer[TIM_W-1 -: 4];
    end
  end

endmodule
